// File: rtl/debounce.sv
// rtl/debounce.sv - N-channel push-button debouncer: 2-flop sync, stability window, press pulse.
// key is active-low; key_pulse fires once per accepted high-to-low change of the stable level.
module debounce #(
   parameter int N       = 1,
   parameter int CNT_MAX = 240000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] key,
   output logic [N-1:0] key_pulse
);

   localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

   logic [N-1:0]  sync1;
   logic [N-1:0]  sync2;
   logic [N-1:0]  key_stable;
   logic [CW-1:0] cnt [N];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1      <= '1;
         sync2      <= '1;
         key_stable <= '1;
         key_pulse  <= '0;
         for (int i = 0; i < N; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1 <= key;
         sync2 <= sync1;
         for (int i = 0; i < N; i++) begin
            key_pulse[i] <= 1'b0;
            if (sync2[i] == key_stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               // An accepted change from 1 means the new level is 0: a press.
               key_stable[i] <= sync2[i];
               key_pulse[i]  <= key_stable[i];
               cnt[i]        <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_debounce.sv
// tb/tb_debounce.sv - self-checking bench for debounce with a window-history reference model.
module tb_debounce;

   localparam int N  = 2;
   localparam int CM = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [N-1:0] key = '1;
   logic [N-1:0] key_pulse;

   int tests = 0;
   int fails = 0;

   debounce #(.N(N), .CNT_MAX(CM)) dut (
      .clk       (clk),
      .rst       (rst),
      .key       (key),
      .key_pulse (key_pulse)
   );

   always #5 clk = ~clk;

   // Reference: a level is accepted once the last CM synchronised samples all disagree with it.
   bit m_s1 [N];
   bit m_s2 [N];
   bit m_stable [N];
   bit hist [N][CM];
   int hn [N];

   int ec;
   int pc [N];
   int pe [N];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, ec);
      end
   endtask

   function automatic void model_reset();
      for (int c = 0; c < N; c++) begin
         m_s1[c]     = 1'b1;
         m_s2[c]     = 1'b1;
         m_stable[c] = 1'b1;
         hn[c]       = 0;
      end
   endfunction

   function automatic logic [N-1:0] model_edge(input logic [N-1:0] k);
      logic [N-1:0] p;
      bit s2;
      bit diff;
      p = '0;
      for (int c = 0; c < N; c++) begin
         s2       = m_s2[c];
         m_s2[c]  = m_s1[c];
         m_s1[c]  = k[c];
         if (hn[c] < CM) begin
            hist[c][hn[c]] = s2;
            hn[c]++;
         end else begin
            for (int j = 0; j < CM - 1; j++) hist[c][j] = hist[c][j+1];
            hist[c][CM-1] = s2;
         end
         if (hn[c] == CM) begin
            diff = 1'b1;
            for (int j = 0; j < CM; j++) if (hist[c][j] == m_stable[c]) diff = 1'b0;
            if (diff) begin
               p[c]        = m_stable[c];
               m_stable[c] = ~m_stable[c];
               hn[c]       = 0;
            end
         end
      end
      return p;
   endfunction

   task automatic clr();
      ec = 0;
      for (int c = 0; c < N; c++) begin
         pc[c] = 0;
         pe[c] = 0;
      end
   endtask

   task automatic step(input logic [N-1:0] k, input string tag);
      logic [N-1:0] e;
      key = k;
      @(posedge clk);
      e = model_edge(k);
      #1;
      ec++;
      check(tag, 32'(key_pulse), 32'(e));
      for (int c = 0; c < N; c++) begin
         if (key_pulse[c] === 1'b1) begin
            pc[c]++;
            if (pe[c] == 0) pe[c] = ec;
         end
      end
   endtask

   task automatic do_reset(input int n, input bit toggle);
      rst = 1'b0;
      model_reset();
      #1;
      check("rst_async", 32'(key_pulse), 32'd0);
      for (int i = 0; i < n; i++) begin
         if (toggle) key = N'($urandom);
         @(posedge clk);
         #1;
         check("rst_hold", 32'(key_pulse), 32'd0);
      end
      rst = 1'b1;
   endtask

   initial begin
      logic [N-1:0] k;
      int run [N];
      int settle;

      model_reset();
      ec = 0;
      #2;
      do_reset(6, 1'b1);

      clr();
      repeat (50) step('1, "idle");
      check("idle_pulses", 32'(pc[0] + pc[1]), 32'd0);

      clr();
      repeat (100) step(2'b10, "press");
      check("press_count", 32'(pc[0]), 32'd1);
      check("press_edge", 32'(pe[0]), 32'(CM + 2));
      check("press_b1", 32'(pc[1]), 32'd0);
      clr();
      repeat (30) step('1, "release");
      check("release_count", 32'(pc[0]), 32'd0);

      clr();
      for (int i = 0; i < 40; i++) step(((i / 3) % 2) ? 2'b11 : 2'b10, "bounce_dn");
      settle = ec;
      repeat (40) step(2'b10, "settle_dn");
      check("bounce_count", 32'(pc[0]), 32'd1);
      check("bounce_edge", 32'(pe[0] - settle), 32'(CM + 2));
      clr();
      for (int i = 0; i < 40; i++) step(((i / 3) % 2) ? 2'b10 : 2'b11, "bounce_up");
      repeat (30) step('1, "settle_up");
      check("bounce_up_count", 32'(pc[0]), 32'd0);

      clr();
      repeat (CM - 1) step(2'b10, "glitch_short");
      repeat (30) step('1, "glitch_short_hi");
      check("glitch_short_count", 32'(pc[0]), 32'd0);
      clr();
      repeat (CM) step(2'b10, "glitch_exact");
      repeat (30) step('1, "glitch_exact_hi");
      check("glitch_exact_count", 32'(pc[0]), 32'd1);
      check("glitch_exact_edge", 32'(pe[0]), 32'(CM + 2));

      clr();
      repeat (7) step(2'b10, "pre_reset");
      check("pre_reset_count", 32'(pc[0]), 32'd0);
      do_reset(2, 1'b0);
      clr();
      repeat (30) step(2'b10, "post_reset");
      check("post_reset_count", 32'(pc[0]), 32'd1);
      check("post_reset_edge", 32'(pe[0]), 32'(CM + 2));
      repeat (30) step('1, "post_reset_rel");

      clr();
      repeat (5) begin
         repeat (15) step(2'b10, "rep_press");
         repeat (15) step(2'b11, "rep_release");
      end
      check("rep_b0", 32'(pc[0]), 32'd5);
      check("rep_b1", 32'(pc[1]), 32'd0);

      clr();
      k = '1;
      for (int c = 0; c < N; c++) run[c] = 0;
      repeat (3000) begin
         for (int c = 0; c < N; c++) begin
            if (run[c] == 0) begin
               k[c]   = ~k[c];
               run[c] = int'($urandom_range(1, 2 * CM + 4));
            end
            run[c]--;
         end
         step(k, "random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
